// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, T-states and control-word bits.
package cpu_pkg;

   typedef enum logic [3:0] {
      OpNop = 4'h0,
      OpLda = 4'h1,
      OpAdd = 4'h2,
      OpSub = 4'h3,
      OpSta = 4'h4,
      OpLdi = 4'h5,
      OpJmp = 4'h6,
      OpJc  = 4'h7,
      OpJz  = 4'h8,
      OpOut = 4'hE,
      OpHlt = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   localparam int unsigned CtrlW = 16;

   // Control-word bit positions
   localparam int unsigned CW_HLT_BIT = 15;
   localparam int unsigned CW_MI_BIT  = 14;
   localparam int unsigned CW_RI_BIT  = 13;
   localparam int unsigned CW_RO_BIT  = 12;
   localparam int unsigned CW_IO_BIT  = 11;
   localparam int unsigned CW_II_BIT  = 10;
   localparam int unsigned CW_AI_BIT  = 9;
   localparam int unsigned CW_AO_BIT  = 8;
   localparam int unsigned CW_EO_BIT  = 7;
   localparam int unsigned CW_SU_BIT  = 6;
   localparam int unsigned CW_BI_BIT  = 5;
   localparam int unsigned CW_OI_BIT  = 4;
   localparam int unsigned CW_CE_BIT  = 3;
   localparam int unsigned CW_CO_BIT  = 2;
   localparam int unsigned CW_J_BIT   = 1;
   localparam int unsigned CW_FI_BIT  = 0;

   // Control-word masks
   localparam logic [CtrlW-1:0] CW_HLT = 16'h8000;
   localparam logic [CtrlW-1:0] CW_MI  = 16'h4000;
   localparam logic [CtrlW-1:0] CW_RI  = 16'h2000;
   localparam logic [CtrlW-1:0] CW_RO  = 16'h1000;
   localparam logic [CtrlW-1:0] CW_IO  = 16'h0800;
   localparam logic [CtrlW-1:0] CW_II  = 16'h0400;
   localparam logic [CtrlW-1:0] CW_AI  = 16'h0200;
   localparam logic [CtrlW-1:0] CW_AO  = 16'h0100;
   localparam logic [CtrlW-1:0] CW_EO  = 16'h0080;
   localparam logic [CtrlW-1:0] CW_SU  = 16'h0040;
   localparam logic [CtrlW-1:0] CW_BI  = 16'h0020;
   localparam logic [CtrlW-1:0] CW_OI  = 16'h0010;
   localparam logic [CtrlW-1:0] CW_CE  = 16'h0008;
   localparam logic [CtrlW-1:0] CW_CO  = 16'h0004;
   localparam logic [CtrlW-1:0] CW_J   = 16'h0002;
   localparam logic [CtrlW-1:0] CW_FI  = 16'h0001;

   // Fetch words shared by every opcode
   localparam logic [CtrlW-1:0] FETCH0_W = CW_CO | CW_MI;
   localparam logic [CtrlW-1:0] FETCH1_W = CW_RO | CW_II | CW_CE;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> 16-bit control word.
module microcode_rom
   import cpu_pkg::*;
(
   input  logic [3:0]       opcode_i,
   input  logic [2:0]       step_i,
   input  logic             carry_i,
   input  logic             zero_i,
   output logic [CtrlW-1:0] word_o
);

   logic [CtrlW-1:0] ex2, ex3, ex4;

   // Execute-phase words per opcode; unlisted opcodes decode as NOP
   always_comb begin
      ex2 = '0;
      ex3 = '0;
      ex4 = '0;
      case (opcode_e'(opcode_i))
         OpLda: begin
            ex2 = CW_IO | CW_MI;
            ex3 = CW_RO | CW_AI;
         end
         OpAdd: begin
            ex2 = CW_IO | CW_MI;
            ex3 = CW_RO | CW_BI;
            ex4 = CW_EO | CW_AI | CW_FI;
         end
         OpSub: begin
            ex2 = CW_IO | CW_MI;
            ex3 = CW_RO | CW_BI;
            ex4 = CW_EO | CW_AI | CW_SU | CW_FI;
         end
         OpSta: begin
            ex2 = CW_IO | CW_MI;
            ex3 = CW_AO | CW_RI;
         end
         OpLdi: ex2 = CW_IO | CW_AI;
         OpJmp: ex2 = CW_IO | CW_J;
         OpJc:  ex2 = carry_i ? (CW_IO | CW_J) : '0;
         OpJz:  ex2 = zero_i ? (CW_IO | CW_J) : '0;
         OpOut: ex2 = CW_AO | CW_OI;
         OpHlt: ex2 = CW_HLT;
         default: ;
      endcase
   end

   // Select the word for the requested T-state; steps past T4 read as zero
   always_comb begin
      word_o = '0;
      case (tstate_e'(step_i))
         T0: word_o = FETCH0_W;
         T1: word_o = FETCH1_W;
         T2: word_o = ex2;
         T3: word_o = ex3;
         T4: word_o = ex4;
         default: word_o = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, halt latch and control-word gating for the 8-bit CPU.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned NUM_STEPS = 5,
   parameter bit          EARLY_END = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_en_i,
   input  logic [3:0]       opcode_i,
   input  logic             carry_flag_i,
   input  logic             zero_flag_i,
   output logic [CtrlW-1:0] ctrl_o,
   output logic [2:0]       step_o,
   output logic             halted_o
);

   localparam logic [2:0] LastStep = 3'(NUM_STEPS - 1);

   logic [2:0]       step_q, step_d, step_nxt;
   logic             halted_q, halted_d;
   logic [CtrlW-1:0] word_cur, word_nxt;

   assign step_nxt = step_q + 3'd1;

   microcode_rom u_rom_cur (
      .opcode_i (opcode_i),
      .step_i   (step_q),
      .carry_i  (carry_flag_i),
      .zero_i   (zero_flag_i),
      .word_o   (word_cur)
   );

   // Lookahead copy decides whether the instruction can end early
   microcode_rom u_rom_nxt (
      .opcode_i (opcode_i),
      .step_i   (step_nxt),
      .carry_i  (carry_flag_i),
      .zero_i   (zero_flag_i),
      .word_o   (word_nxt)
   );

   // Next-state: halt latch, wrap, early end or plain increment
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (run_en_i && !halted_q) begin
         if (word_cur[CW_HLT_BIT]) begin
            halted_d = 1'b1;  // step freezes at the HLT T-state
         end else if (step_q == LastStep) begin
            step_d = '0;
         end else if (EARLY_END && (step_q != '0) && (word_nxt == '0)) begin
            step_d = '0;
         end else begin
            step_d = step_nxt;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Gate the word so a stalled or halted cycle never repeats CE or a RAM write
   always_comb begin
      ctrl_o = '0;
      if (rst_ni && run_en_i && !halted_q) ctrl_o = word_cur;
   end

   assign step_o   = step_q;
   assign halted_o = halted_q;

endmodule
